// File: rtl/dfe_rate_scheduler_pkg.sv
// Shared types, defaults and config validity rule for the DFE rate scheduler.
package dfe_sched_pkg;

  localparam int DEF_RATIO_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } sched_state_e;

  function automatic logic cfg_is_valid(input int unsigned num, input int unsigned den);
    return (num >= 1) && (den >= 1) && (num <= den);
  endfunction

endpackage

// File: rtl/dfe_rate_scheduler_if.sv
// Control/config/enable bundle between the scheduler and its user.
interface dfe_rate_scheduler_if
  import dfe_sched_pkg::*;
#(
  parameter int RATIO_WIDTH = DEF_RATIO_WIDTH,
  parameter int NUM_STAGES  = 3
);
  logic                   run;
  // Config transfer happens on a clock edge where cfg_valid and cfg_ready are both 1;
  // cfg_num/cfg_den must be stable while cfg_valid is high and ready is low.
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [RATIO_WIDTH-1:0] cfg_num;
  logic [RATIO_WIDTH-1:0] cfg_den;
  logic                   cfg_err;
  logic                   busy;
  logic                   frac_en;
  logic [NUM_STAGES-1:0]  stage_en;
  logic                   frame_sync;

  modport master (
    output run, cfg_valid, cfg_num, cfg_den,
    input  cfg_ready, cfg_err, busy, frac_en, stage_en, frame_sync
  );

  modport slave (
    input  run, cfg_valid, cfg_num, cfg_den,
    output cfg_ready, cfg_err, busy, frac_en, stage_en, frame_sync
  );
endinterface

// File: rtl/dfe_rate_scheduler_frac_accum.sv
// Phase counter and P/Q accumulator; reports this cycle's pulse and frame position.
module dfe_frac_accum #(
  parameter int RATIO_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   step,
  input  logic [RATIO_WIDTH-1:0] num,
  input  logic [RATIO_WIDTH-1:0] den,
  output logic                   pulse,
  output logic                   at_boundary,
  output logic                   at_start
);
  logic [RATIO_WIDTH-1:0] phase;
  logic [RATIO_WIDTH-1:0] acc;
  logic [RATIO_WIDTH:0]   sum;

  // One extra bit so acc+P never wraps even with P, Q near 2^RATIO_WIDTH-1.
  always_comb begin
    sum         = {1'b0, acc} + {1'b0, num};
    pulse       = (sum >= {1'b0, den});
    at_boundary = (phase == den - RATIO_WIDTH'(1));
    at_start    = (phase == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      phase <= '0;
      acc   <= '0;
    end else if (step) begin
      acc   <= pulse ? RATIO_WIDTH'(sum - {1'b0, den}) : sum[RATIO_WIDTH-1:0];
      phase <= at_boundary ? '0 : phase + RATIO_WIDTH'(1);
    end
  end
endmodule

// File: rtl/dfe_rate_scheduler.sv
// Fractional-rate clock-enable scheduler with frame-aligned config updates and stage dividers.
module dfe_rate_scheduler
  import dfe_sched_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int RATIO_WIDTH = DEF_RATIO_WIDTH,
  parameter int DEF_NUM     = 2,
  parameter int DEF_DEN     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  dfe_rate_scheduler_if.slave  bus,
  output sched_state_e         dbg_state
);
  localparam int CW = (NUM_STAGES > 1) ? NUM_STAGES - 1 : 1;

  sched_state_e state, state_next;
  logic proc, clear, busy_c;

  logic pulse, at_boundary, at_start;
  logic accept, cfg_ok, boundary_edge;

  logic [RATIO_WIDTH-1:0] act_num, act_den, pend_num, pend_den;
  logic                   pend_valid;
  logic                   cfg_ready_q, cfg_err_q;
  logic                   frac_en_q, frame_sync_q;
  logic [NUM_STAGES-1:0]  stage_en_q;
  logic [CW-1:0]          pulse_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Run has priority at the STOPPING boundary so a late re-assert leaves no gap.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (bus.run) state_next = RUN;
      RUN:      if (!bus.run) state_next = STOPPING;
      STOPPING: begin
        if (bus.run)          state_next = RUN;
        else if (at_boundary) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    proc   = (state != IDLE);
    clear  = (state == IDLE) && bus.run;
    busy_c = (state != IDLE);
  end

  dfe_frac_accum #(.RATIO_WIDTH(RATIO_WIDTH)) u_accum (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .step        (proc),
    .num         (act_num),
    .den         (act_den),
    .pulse       (pulse),
    .at_boundary (at_boundary),
    .at_start    (at_start)
  );

  always_comb begin
    accept        = bus.cfg_valid && cfg_ready_q;
    cfg_ok        = cfg_is_valid(32'(bus.cfg_num), 32'(bus.cfg_den));
    boundary_edge = proc && at_boundary;
  end

  // Active ratio only changes outside a frame: in IDLE, or on the boundary edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_num     <= RATIO_WIDTH'(DEF_NUM);
      act_den     <= RATIO_WIDTH'(DEF_DEN);
      pend_num    <= '0;
      pend_den    <= '0;
      pend_valid  <= 1'b0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= accept && !cfg_ok;
      if (!proc) begin
        if (accept && cfg_ok) begin
          act_num <= bus.cfg_num;
          act_den <= bus.cfg_den;
        end
      end else if (boundary_edge) begin
        if (accept && cfg_ok) begin
          pend_num <= bus.cfg_num;
          pend_den <= bus.cfg_den;
          act_num  <= bus.cfg_num;
          act_den  <= bus.cfg_den;
        end else if (pend_valid) begin
          act_num <= pend_num;
          act_den <= pend_den;
        end
        pend_valid  <= 1'b0;
        cfg_ready_q <= 1'b1;
      end else if (accept && cfg_ok) begin
        pend_num    <= bus.cfg_num;
        pend_den    <= bus.cfg_den;
        pend_valid  <= 1'b1;
        cfg_ready_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frac_en_q    <= 1'b0;
      frame_sync_q <= 1'b0;
      stage_en_q   <= '0;
      pulse_cnt    <= '0;
    end else if (proc) begin
      frac_en_q     <= pulse;
      frame_sync_q  <= at_start;
      stage_en_q[0] <= pulse;
      for (int i = 1; i < NUM_STAGES; i++)
        stage_en_q[i] <= pulse && ((pulse_cnt & CW'((1 << i) - 1)) == '0);
      if (pulse) pulse_cnt <= pulse_cnt + CW'(1);
    end else begin
      frac_en_q    <= 1'b0;
      frame_sync_q <= 1'b0;
      stage_en_q   <= '0;
      if (clear) pulse_cnt <= '0;
    end
  end

  assign bus.cfg_ready  = cfg_ready_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.busy       = busy_c;
  assign bus.frac_en    = frac_en_q;
  assign bus.frame_sync = frame_sync_q;
  assign bus.stage_en   = stage_en_q;
  assign dbg_state      = state;
endmodule

// File: tb/tb_dfe_rate_scheduler.sv
// Directed plus randomized checks of the rate scheduler against a frame-arithmetic reference model.
module tb_dfe_rate_scheduler;
  import dfe_sched_pkg::*;

  localparam int NS = 3;
  localparam int RW = 8;

  logic clk = 1'b0;
  logic rst;
  sched_state_e dbg_state;

  dfe_rate_scheduler_if #(.RATIO_WIDTH(RW), .NUM_STAGES(NS)) bus ();

  dfe_rate_scheduler #(
    .NUM_STAGES(NS), .RATIO_WIDTH(RW), .DEF_NUM(2), .DEF_DEN(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 running, 2 stopping; k is the index within the frame.
  int m_mode, m_k, m_p, m_q, m_pp, m_pq, m_pulses;
  bit m_pend, m_ready;
  logic e_frac, e_sync, e_busy, e_err;
  logic [NS-1:0] e_stage;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_p = 2; m_q = 3; m_pp = 0; m_pq = 0; m_pulses = 0;
    m_pend = 0; m_ready = 1;
    e_frac = 0; e_sync = 0; e_busy = 0; e_err = 0; e_stage = '0;
  endtask

  task automatic model_step();
    int n, d, pulse;
    bit acc, ok, boundary;
    if (rst) begin
      model_reset();
      return;
    end
    n = int'(bus.cfg_num);
    d = int'(bus.cfg_den);
    acc = bus.cfg_valid && m_ready;
    ok = (n >= 1) && (d >= 1) && (n <= d);
    e_err = acc && !ok;
    if (m_mode == 0) begin
      e_frac = 0; e_sync = 0; e_stage = '0;
      if (acc && ok) begin m_p = n; m_q = d; end
      if (bus.run) begin m_mode = 1; m_k = 0; m_pulses = 0; end
    end else begin
      // Pulse count up to and including cycle k is floor((k+1)P/Q).
      pulse = ((m_k + 1) * m_p) / m_q - (m_k * m_p) / m_q;
      e_frac = (pulse != 0);
      e_sync = (m_k == 0);
      for (int i = 0; i < NS; i++)
        e_stage[i] = (pulse != 0) && ((m_pulses % (1 << i)) == 0);
      if (pulse != 0) m_pulses++;
      boundary = (m_k == m_q - 1);
      m_k = boundary ? 0 : m_k + 1;
      if (boundary) begin
        if (acc && ok) begin m_p = n; m_q = d; end
        else if (m_pend) begin m_p = m_pp; m_q = m_pq; end
        m_pend = 0; m_ready = 1;
      end else if (acc && ok) begin
        m_pp = n; m_pq = d; m_pend = 1; m_ready = 0;
      end
      if (m_mode == 1) m_mode = bus.run ? 1 : 2;
      else             m_mode = bus.run ? 1 : (boundary ? 0 : 2);
    end
    e_busy = (m_mode != 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("frac_en", 32'(bus.frac_en), 32'(e_frac));
    check("stage_en", 32'(bus.stage_en), 32'(e_stage));
    check("frame_sync", 32'(bus.frame_sync), 32'(e_sync));
    check("busy", 32'(bus.busy), 32'(e_busy));
    check("cfg_ready", 32'(bus.cfg_ready), 32'(m_ready));
    check("cfg_err", 32'(bus.cfg_err), 32'(e_err));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_cfg(input int n, input int d);
    bus.cfg_valid = 1'b1;
    bus.cfg_num = RW'(n);
    bus.cfg_den = RW'(d);
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600 && m_mode != 0; i++) tick();
    check("idle_reached", 32'(bus.busy), 32'(0));
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    bus.run = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_num = '0;
    bus.cfg_den = '0;
    ticks(2);
    rst = 1'b0;
    ticks(2);

    // Default 2/3 schedule.
    bus.run = 1'b1;
    ticks(13);

    // Ratio change offered at phase 0 while running.
    for (int i = 0; i < 10 && !(m_mode == 1 && m_k == 0); i++) tick();
    send_cfg(1, 4);
    ticks(14);

    // Stop, restore 2/3, then an invalid 5/3 in idle.
    bus.run = 1'b0;
    wait_idle();
    send_cfg(2, 3);
    send_cfg(5, 3);
    ticks(2);
    send_cfg(0, 3);
    tick();
    bus.run = 1'b1;
    ticks(9);

    // Drop run mid-frame and let the frame finish.
    for (int i = 0; i < 10 && m_k != 1; i++) tick();
    bus.run = 1'b0;
    wait_idle();
    ticks(2);

    // Re-assert run before the boundary.
    bus.run = 1'b1;
    ticks(4);
    bus.run = 1'b0;
    tick();
    bus.run = 1'b1;
    ticks(8);
    bus.run = 1'b0;
    wait_idle();

    // Full-rate 7/7, then reset mid-frame.
    send_cfg(7, 7);
    bus.run = 1'b1;
    ticks(11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.run = 1'b0;
    tick();
    bus.run = 1'b1;
    ticks(7);
    bus.run = 1'b0;
    wait_idle();

    // Widest denominator exercises the full-width phase wrap.
    send_cfg(3, 255);
    bus.run = 1'b1;
    ticks(520);
    bus.run = 1'b0;
    wait_idle();
    send_cfg(254, 255);
    bus.run = 1'b1;
    ticks(260);

    // Randomized run/config/reset traffic.
    for (int it = 0; it < 1500; it++) begin
      int d;
      if ($urandom_range(0, 24) == 0) bus.run = ~bus.run;
      d = $urandom_range(0, 9);
      bus.cfg_valid = ($urandom_range(0, 3) == 0);
      bus.cfg_den = RW'(d);
      bus.cfg_num = RW'($urandom_range(0, d + 1));
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.run = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
